stage_skid_reg: RTL



---
 rtl/pipe_pkg.sv | 32 +++
 rtl/skid_entry.sv | 27 ++
 rtl/stage_skid_reg.sv | 112 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the decode/execute pipeline stages: the stage FSM
// states, default field widths and field offsets within the ctrl/data payload.
package pipe_pkg;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  localparam int CTRL_W_DEF = 9;
  localparam int DATA_W_DEF = 137;

  // control field bit positions
  localparam int CTRL_WB_EN    = 8;
  localparam int CTRL_MEM_R_EN = 7;
  localparam int CTRL_MEM_W_EN = 6;
  localparam int CTRL_B        = 5;
  localparam int CTRL_S        = 4;
  localparam int CTRL_EXE_LSB  = 0;
  localparam int CTRL_EXE_W    = 4;

  // data field LSB offsets, packed from Dest upward to PC
  localparam int DATA_DEST_LSB   = 0;
  localparam int DATA_DEST_W     = 4;
  localparam int DATA_SIMM24_LSB = 4;
  localparam int DATA_SIMM24_W   = 24;
  localparam int DATA_SHOP_LSB   = 28;
  localparam int DATA_SHOP_W     = 12;
  localparam int DATA_IMM_BIT    = 40;
  localparam int DATA_VAL_RM_LSB = 41;
  localparam int DATA_VAL_RN_LSB = 73;
  localparam int DATA_PC_LSB     = 105;
  localparam int DATA_WORD_W     = 32;

endpackage

// File: rtl/skid_entry.sv
// One payload slot of the stage register: payload flops plus a valid bit.
// clear wins over load; reset zeroes payload and valid.
module skid_entry #(
  parameter int W = 146
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/stage_skid_reg.sv
// Decode-to-execute stage register with a two-entry skid buffer and flush.
// Optional macro STAGE_REG_CTRL_SQUASH_EN zeroes out_ctrl whenever out_valid is low.
module stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam int PW = CTRL_W + DATA_W;

  state_t          state_q, state_d;
  logic            main_valid, skid_valid;
  logic [PW-1:0]   main_q, skid_q, main_d;
  logic            main_load, main_from_skid, main_clr;
  logic            skid_load, skid_clr;
  logic            accept, pop;

  // in_ready comes straight from the skid valid flop, so no out_ready path
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid & in_ready;
  assign pop       = main_valid & out_ready;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
        ST_ONE: begin
          if (accept && !pop) begin
            skid_load = 1'b1;
            state_d   = ST_TWO;
          end else if (accept && pop) begin
            main_load = 1'b1;
          end else if (pop) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_TWO: if (pop) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clr       = 1'b1;
          state_d        = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : {in_ctrl, in_data};

  skid_entry #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  skid_entry #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clr),
    .d     ({in_ctrl, in_data}),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign out_data = main_q[DATA_W-1:0];
`ifdef STAGE_REG_CTRL_SQUASH_EN
  assign out_ctrl = main_valid ? main_q[PW-1 -: CTRL_W] : '0;
`else
  assign out_ctrl = main_q[PW-1 -: CTRL_W];
`endif

endmodule
